updi_tx_phy: RTL

//  UPDI transmit PHY. Serialises bytes into UPDI frames: 1 start, 8 data LSB-first, even parity, 2 stop.

---
 rtl/updi_pkg.sv | 18 +
 rtl/updi_bit_timer.sv | 39 +++
 rtl/updi_tx_phy.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/updi_pkg.sv
// rtl/updi_pkg.sv - shared types and constants for the UPDI transmit path
package updi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        GUARD  = 3'd6
    } updi_tx_state_t;

    localparam int         UPDI_FRAME_BITS = 12;
    localparam int         UPDI_STOP_BITS  = 2;
    localparam logic [7:0] UPDI_SYNC       = 8'h55;

endpackage

// File: rtl/updi_bit_timer.sv
// rtl/updi_bit_timer.sv - UPDI baud counter producing per-bit strobes
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   run      in   counter runs while high; held at 0 while low
//   bit_end  out  high on the last cycle of every CLKS_PER_BIT-cycle bit
//   pre_end  out  high on the cycle before bit_end (lets the caller register
//                 strobes that must coincide with bit_end)
module updi_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic pre_end
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] r_cnt;

    // Holding the count at 0 while idle means the first bit after run rises
    // is a full CLKS_PER_BIT cycles long.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bit_end = run && (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign pre_end = run && (r_cnt == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/updi_tx_phy.sv
// rtl/updi_tx_phy.sv - UPDI transmit PHY: 1 start, 8 data LSB-first, even parity, 2 stop
//
// Optional feature macro: UPDI_TX_GUARD_EN (adds GUARD_BITS idle-high bits after each frame).
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   tx_data/valid/ready  byte input handshake
//   brk_busy, brk_pulse  break generator busy flag and line level
//   busy                 frame or break in progress
//   tx_done              1-cycle strobe on the last cycle of a frame
//   tx_abort             1-cycle strobe when a break kills a frame
//   updi_tx, updi_oe     line level and driver enable
module updi_tx_phy
    import updi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int GUARD_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       brk_busy,
    input  logic       brk_pulse,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort,
    output logic       updi_tx,
    output logic       updi_oe
);

    // The bit index counts data bits and, with the guard, guard bits.
    localparam int IDX_W = (GUARD_BITS > 8) ? $clog2(GUARD_BITS) : 3;

    updi_tx_state_t   r_state, w_state_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             r_par, w_par_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_tx_ready, r_busy, r_tx_done, r_tx_abort, r_updi_tx, r_updi_oe;
    logic             w_bit_end, w_pre_end, w_accept, w_last_pre, w_abort, w_level;

    updi_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (r_state != IDLE),
        .bit_end (w_bit_end),
        .pre_end (w_pre_end)
    );

    // A break arriving on the handshake edge wins; the byte is not taken.
    assign w_accept = tx_valid && r_tx_ready && !brk_busy;

    // Next cycle is the final cycle of the frame: tx_done and tx_ready are
    // raised for that cycle so a held tx_valid chains frames without a gap.
`ifdef UPDI_TX_GUARD_EN
    assign w_last_pre = !brk_busy && w_pre_end && (r_state == GUARD) &&
                        (r_idx == IDX_W'(GUARD_BITS - 1));
`else
    assign w_last_pre = !brk_busy && w_pre_end && (r_state == STOP2);
`endif

    // r_tx_done marks the final cycle; a break then does not count as an abort.
    assign w_abort = brk_busy && (r_state != IDLE) && !r_tx_done;

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_idx_next   = r_idx;
        w_level      = 1'b1;
        if (brk_busy) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_next = START;
                START: if (w_bit_end) begin
                    w_state_next = DATA;
                    w_idx_next   = '0;
                end
                DATA: if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_idx == IDX_W'(7)) begin
                        w_state_next = PARITY;
                        w_idx_next   = '0;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
                PARITY: if (w_bit_end) w_state_next = STOP1;
                STOP1:  if (w_bit_end) w_state_next = STOP2;
`ifdef UPDI_TX_GUARD_EN
                STOP2: if (w_bit_end) begin
                    w_state_next = GUARD;
                    w_idx_next   = '0;
                end
                GUARD: if (w_bit_end) begin
                    if (r_idx == IDX_W'(GUARD_BITS - 1)) begin
                        w_state_next = w_accept ? START : IDLE;
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
`else
                STOP2: if (w_bit_end) w_state_next = w_accept ? START : IDLE;
`endif
                default: w_state_next = IDLE;
            endcase
            if (w_accept) begin
                w_shift_next = tx_data;
                w_par_next   = ^tx_data;
            end
        end
        // Line level is registered from the next state so it changes on the
        // same edge as the state.
        case (w_state_next)
            START:   w_level = 1'b0;
            DATA:    w_level = w_shift_next[0];
            PARITY:  w_level = w_par_next;
            default: w_level = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_idx      <= '0;
            r_updi_tx  <= 1'b1;
            r_updi_oe  <= 1'b0;
            r_tx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_abort <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_idx      <= w_idx_next;
            r_updi_tx  <= brk_busy ? brk_pulse : w_level;
            r_updi_oe  <= brk_busy || (w_state_next != IDLE);
            r_busy     <= brk_busy || (w_state_next != IDLE);
            r_tx_ready <= !brk_busy && ((w_state_next == IDLE) || w_last_pre);
            r_tx_done  <= w_last_pre;
            r_tx_abort <= w_abort;
        end
    end

    assign tx_ready = r_tx_ready;
    assign busy     = r_busy;
    assign tx_done  = r_tx_done;
    assign tx_abort = r_tx_abort;
    assign updi_tx  = r_updi_tx;
    assign updi_oe  = r_updi_oe;

endmodule
